mvp_stream_sequencer: RTL and testbench
=======================================

# mvp_stream_sequencer

Streaming front/back end for the 4x4 combinational matrix-vector product datapath. Accepts a 16-bit word stream (matrix row-major, then vector) over a valid/ready handshake and holds the operands in registers driving the product block's inputs. After one settle cycle it captures the four product words and returns them over a second valid/ready stream. Words are opaque 16-bit values to this block; no arithmetic is performed here.

## Interface
- DIM, 4, matrix/vector dimension; only 4 is supported.
- DATA_W, 16, word width in bits.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  DATA_W  input word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts a word this cycle.
- in_vec_only  input  1  sampled only on the first beat of a frame; 1 = frame is 4 vector words only, matrix retained.
- mat_flat  output  DIM*DIM*DATA_W  element (r,c) at bits [(r*DIM+c)*DATA_W +: DATA_W].
- vec_flat  output  DIM*DATA_W  element i at [i*DATA_W +: DATA_W].
- prod_flat  input  DIM*DATA_W  product i at [i*DATA_W +: DATA_W], from the combinational product block.
- out_data  output  DATA_W  result word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_last  output  1  marks product 3.
- busy  output  1  frame in progress (partial input, CAPTURE, or EMIT).

## Operation
- States: LOAD_MAT, LOAD_VEC, CAPTURE, EMIT. Counter idx (0..15 in LOAD_MAT, 0..3 in LOAD_VEC/EMIT).
- in_ready = 1 in LOAD_MAT and LOAD_VEC, else 0. Beat accepted on in_valid && in_ready.
- LOAD_MAT: accepted beat written to matrix element idx (row-major), idx++. Beat at idx 15 -> LOAD_VEC, idx=0.
- First beat of a frame (LOAD_MAT, idx 0) with in_vec_only=1: word goes to vector element 0; state LOAD_VEC, idx=1; matrix untouched. in_vec_only ignored on all other beats.
- LOAD_VEC: beat written to vector element idx; beat at idx 3 -> CAPTURE.
- CAPTURE: one cycle; at its closing edge prod_flat is registered into result regs, idx=0, state EMIT.
- EMIT: out_valid=1, out_data=result[idx], out_last=(idx==3). On out_valid && out_ready: idx++; at idx 3 -> LOAD_MAT, idx=0, out_valid falls next cycle.
- mat_flat/vec_flat change only on accepted beats; stable through CAPTURE and EMIT.
- Reset values: state LOAD_MAT, idx 0, mat_flat 0, vec_flat 0, result regs 0, out_valid 0, out_data 0, out_last 0, busy 0; in_ready reads 1 from the first cycle after reset is sampled.
- Reset mid-frame or mid-EMIT: partial frame and pending results discarded; all registers to reset values, including the matrix.
- in_valid during CAPTURE/EMIT: not accepted (in_ready=0); upstream holds.

## Timing
- Last vector beat accepted at edge T: vec_flat updated at T; CAPTURE during cycle T..T+1; out_valid=1 with product 0 from T+1. Latency from last input beat to first result = 2 cycles.
- prod_flat must settle within one clock after vec_flat updates (combinational product path is single-cycle).
- out_data/out_last held stable while out_valid && !out_ready.
- Back-to-back: after the out_last handshake at edge E, in_ready=1 from E; first beat of the next frame acceptable at E+1.
- Full frame, no stalls: 20 input + 1 capture + 4 output = 25 cycles; vec-only frame: 9 cycles.

## Structure
- Package mvp_pkg: DIM, DATA_W, word_t (logic [DATA_W-1:0]), state enum (LOAD_MAT, LOAD_VEC, CAPTURE, EMIT), flat-index helper for (r,c).
- One sub-module: mvp_result_serializer (capture regs plus EMIT handshake/out_last); loader FSM in the top.
- The product block is a peer instantiated beside this block, not inside it.

## Test plan
- Full frame words 0x0000..0x0013, out_ready=1: mat_flat element (r,c) = 4r+c, vec_flat i = 0x10+i; with prod_flat fixed to {0x4444,0x3333,0x2222,0x1111}, outputs 0x1111,0x2222,0x3333,0x4444 starting 2 cycles after the last beat, out_last on the 4th.
- Vec-only frame {0xAAAA,0xBBBB,0xCCCC,0xDDDD} after the above: mat_flat unchanged, vec_flat updated, 4 results emitted.
- out_ready toggled 1,0,0,1 during EMIT: out_data/out_last stable while stalled; exactly 4 handshakes; in_ready 0 throughout.
- in_valid gaps every other cycle during load: only valid beats stored, idx order preserved, same results as gap-free run.
- rst_n low for 1 cycle after 10 matrix beats: mat_flat=0, busy=0, in_ready=1 next cycle; following full frame processed correctly.
- Back-to-back two full frames with in_valid held high: second frame's first beat accepted the cycle after the first frame's out_last handshake.

Source files
------------

// File: rtl/mvp_pkg.sv
// Shared types for the matrix-vector product stream sequencer.
// Dimension and word width are fixed here; the sequencer supports only DIM = 4.
package mvp_pkg;

  localparam int DIM    = 4;
  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    LOAD_MAT,
    LOAD_VEC,
    CAPTURE,
    EMIT
  } state_t;

  // Row-major position of matrix element (r,c) in the flat operand bus.
  function automatic int flat_idx(input int r, input int c);
    return r * DIM + c;
  endfunction

endpackage

// File: rtl/mvp_result_serializer.sv
// Registers the four product words on capture, then emits them one per handshake.
// Data is valid 1 cycle after capture; out_data/out_last hold steady while out_ready is low.
module mvp_result_serializer
  import mvp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture,
  input  logic [DIM*DATA_W-1:0] prod_flat,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  done
);

  localparam int             EW   = $clog2(DIM);
  localparam logic [EW-1:0]  LAST = EW'(DIM - 1);

  word_t         res_q [DIM];
  logic          vld_q;
  logic [EW-1:0] eidx_q;
  logic          fire;

  assign fire = vld_q && out_ready;
  assign done = fire && (eidx_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++) res_q[i] <= '0;
      vld_q  <= 1'b0;
      eidx_q <= '0;
    end else if (capture) begin
      for (int i = 0; i < DIM; i++) res_q[i] <= prod_flat[i*DATA_W +: DATA_W];
      vld_q  <= 1'b1;
      eidx_q <= '0;
    end else if (fire) begin
      if (eidx_q == LAST) begin
        vld_q  <= 1'b0;
        eidx_q <= '0;
      end else begin
        eidx_q <= eidx_q + 1'b1;
      end
    end
  end

  assign out_valid = vld_q;
  assign out_data  = res_q[eidx_q];
  assign out_last  = vld_q && (eidx_q == LAST);

endmodule

// File: rtl/mvp_stream_sequencer.sv
// Loads matrix/vector operands from a word stream and streams back the four products.
// Last input beat to first result: 2 cycles; input is refused (in_ready=0) during capture and emit.
module mvp_stream_sequencer #(
  parameter int DIM    = 4,
  parameter int DATA_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_vec_only,
  output logic [DIM*DIM*DATA_W-1:0] mat_flat,
  output logic [DIM*DATA_W-1:0]     vec_flat,
  input  logic [DIM*DATA_W-1:0]     prod_flat,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy
);

  import mvp_pkg::*;

  localparam int NM = DIM * DIM;
  localparam int IW = $clog2(NM);
  localparam int VW = $clog2(DIM);
  localparam logic [IW-1:0] MAT_LAST = IW'(NM - 1);
  localparam logic [IW-1:0] VEC_LAST = IW'(DIM - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] mat_q [NM];
  logic [DATA_W-1:0] vec_q [DIM];
  logic              acc;
  logic              mat_we;
  logic              vec_we;
  logic [VW-1:0]     vec_sel;
  logic              capture;
  logic              emit_done;

  assign in_ready = (state_q == LOAD_MAT) || (state_q == LOAD_VEC);
  assign acc      = in_valid && in_ready;
  // Idle means waiting for the first beat of a frame; anything else is mid-frame.
  assign busy     = (state_q != LOAD_MAT) || (idx_q != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mat_we  = 1'b0;
    vec_we  = 1'b0;
    vec_sel = idx_q[VW-1:0];
    capture = 1'b0;
    case (state_q)
      LOAD_MAT: begin
        if (acc) begin
          if ((idx_q == '0) && in_vec_only) begin
            vec_we  = 1'b1;
            vec_sel = '0;
            state_d = LOAD_VEC;
            idx_d   = IW'(1);
          end else begin
            mat_we = 1'b1;
            if (idx_q == MAT_LAST) begin
              state_d = LOAD_VEC;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      LOAD_VEC: begin
        if (acc) begin
          vec_we = 1'b1;
          if (idx_q == VEC_LAST) begin
            state_d = CAPTURE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = EMIT;
        idx_d   = '0;
      end
      EMIT: begin
        if (emit_done) begin
          state_d = LOAD_MAT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = LOAD_MAT;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD_MAT;
      idx_q   <= '0;
      for (int i = 0; i < NM; i++) mat_q[i] <= '0;
      for (int i = 0; i < DIM; i++) vec_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (mat_we) mat_q[idx_q] <= in_data;
      if (vec_we) vec_q[vec_sel] <= in_data;
    end
  end

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      localparam int K = flat_idx(r, c);
      assign mat_flat[K*DATA_W +: DATA_W] = mat_q[K];
    end
    assign vec_flat[r*DATA_W +: DATA_W] = vec_q[r];
  end

  mvp_result_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .prod_flat (prod_flat),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .done      (emit_done)
  );

endmodule

// File: tb/tb_mvp_stream_sequencer.sv
// Directed bench for mvp_stream_sequencer; the bench plays the product block with fixed prod_flat.
module tb_mvp_stream_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_vec_only;
  logic [255:0] mat_flat;
  logic [63:0]  vec_flat;
  logic [63:0]  prod_flat;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mvp_stream_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vec_only (in_vec_only),
    .mat_flat    (mat_flat),
    .vec_flat    (vec_flat),
    .prod_flat   (prod_flat),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [255:0] build_mat(input logic [15:0] base);
    logic [255:0] m;
    m = '0;
    for (int k = 0; k < 16; k++) m[k*16 +: 16] = base + 16'(k);
    return m;
  endfunction

  function automatic logic [255:0] build_vec(input logic [15:0] base);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k*16 +: 16] = base + 16'(k);
    return v;
  endfunction

  task automatic set_prod(input logic [15:0] p0, input logic [15:0] p1,
                          input logic [15:0] p2, input logic [15:0] p3);
    prod_flat = {p3, p2, p1, p0};
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.d = prod_flat[i*16 +: 16];
      e.l = (i == 3);
      q.push_back(e);
    end
  endtask

  // Presents one word and returns at the negedge after it is accepted.
  task automatic send(input logic [15:0] w, input logic vo);
    int n;
    n = 0;
    in_data     = w;
    in_valid    = 1'b1;
    in_vec_only = vo;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("send_ready_timeout", {255'b0, in_ready}, 256'd1);
    else tick();
    in_vec_only = 1'b0;
  endtask

  // Twenty-word frame; with gaps, an idle cycle follows each beat and in_vec_only is
  // driven high on every non-first beat, where it must be ignored.
  task automatic frame(input logic [15:0] base, input bit gaps, input bit keep);
    for (int k = 0; k < 20; k++) begin
      send(base + 16'(k), (k != 0) && gaps);
      if (gaps && k != 19) begin
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        tick();
      end
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain(input logic [7:0] pat, input bit scramble);
    int hs;
    int idle;
    int cyc;
    hs = 0; idle = 0; cyc = 0;
    while (q.size() > 0 && idle < 64) begin
      if (out_valid) begin
        out_ready = pat[cyc % 8];
        cyc++;
        chk("out_data", {240'b0, out_data}, {240'b0, q[0].d});
        chk("out_last", {255'b0, out_last}, {255'b0, q[0].l});
        chk("emit_in_ready", {255'b0, in_ready}, 256'd0);
        if (scramble) prod_flat = ~prod_flat;
        if (out_ready) begin
          void'(q.pop_front());
          hs++;
        end
      end else begin
        out_ready = pat[0];
        idle++;
      end
      tick();
    end
    out_ready = 1'b1;
    chk("drain_pending", 256'(q.size()), 256'd0);
    chk("handshakes", 256'(hs), 256'd4);
    chk("post_out_valid", {255'b0, out_valid}, 256'd0);
    chk("post_in_ready", {255'b0, in_ready}, 256'd1);
    q.delete();
  endtask

  initial begin
    rst_n       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    in_vec_only = 1'b0;
    out_ready   = 1'b1;
    prod_flat   = '0;
    tick(); tick();
    rst_n = 1'b1;

    chk("rst_in_ready", {255'b0, in_ready}, 256'd1);
    chk("rst_busy", {255'b0, busy}, 256'd0);
    chk("rst_out_valid", {255'b0, out_valid}, 256'd0);
    chk("rst_out_data", {240'b0, out_data}, 256'd0);
    chk("rst_out_last", {255'b0, out_last}, 256'd0);
    chk("rst_mat", mat_flat, 256'd0);
    chk("rst_vec", {192'b0, vec_flat}, 256'd0);

    // Full frame 0x0000..0x0013 with two-cycle latency check.
    set_prod(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    frame(16'h0000, 1'b0, 1'b0);
    chk("f1_mat", mat_flat, build_mat(16'h0000));
    chk("f1_vec", {192'b0, vec_flat}, build_vec(16'h0010));
    chk("f1_capture_valid", {255'b0, out_valid}, 256'd0);
    chk("f1_capture_busy", {255'b0, busy}, 256'd1);
    chk("f1_capture_in_ready", {255'b0, in_ready}, 256'd0);
    tick();
    chk("f1_latency_valid", {255'b0, out_valid}, 256'd1);
    drain(8'hFF, 1'b0);
    chk("f1_idle_busy", {255'b0, busy}, 256'd0);

    // Vector-only frame retains the matrix.
    set_prod(16'h5555, 16'h6666, 16'h7777, 16'h8888);
    send(16'hAAAA, 1'b1);
    chk("vo_busy", {255'b0, busy}, 256'd1);
    send(16'hBBBB, 1'b0);
    send(16'hCCCC, 1'b0);
    send(16'hDDDD, 1'b0);
    in_valid = 1'b0;
    chk("vo_mat", mat_flat, build_mat(16'h0000));
    chk("vo_vec", {192'b0, vec_flat}, {192'b0, 64'hDDDD_CCCC_BBBB_AAAA});
    drain(8'hFF, 1'b0);

    // Stalled emit; prod_flat is disturbed during EMIT to prove results are registered.
    set_prod(16'h9999, 16'h8888, 16'h7777, 16'h6666);
    send(16'h0101, 1'b1);
    send(16'h0202, 1'b0);
    send(16'h0303, 1'b0);
    send(16'h0404, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    drain(8'b1001_1001, 1'b1);
    in_valid = 1'b0;
    chk("stall_vec", {192'b0, vec_flat}, {192'b0, 64'h0404_0303_0202_0101});

    // Gapped frame, in_vec_only high on non-first beats.
    set_prod(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    frame(16'h0020, 1'b1, 1'b0);
    chk("gap_mat", mat_flat, build_mat(16'h0020));
    chk("gap_vec", {192'b0, vec_flat}, build_vec(16'h0030));
    drain(8'hFF, 1'b0);

    // Reset after 10 matrix beats discards everything.
    for (int k = 0; k < 10; k++) send(16'h0300 + 16'(k), 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_busy", {255'b0, busy}, 256'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_mat", mat_flat, 256'd0);
    chk("mid_rst_vec", {192'b0, vec_flat}, 256'd0);
    chk("mid_rst_busy", {255'b0, busy}, 256'd0);
    chk("mid_rst_in_ready", {255'b0, in_ready}, 256'd1);
    set_prod(16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4);
    frame(16'h0040, 1'b0, 1'b0);
    chk("post_rst_mat", mat_flat, build_mat(16'h0040));
    chk("post_rst_vec", {192'b0, vec_flat}, build_vec(16'h0050));
    drain(8'hFF, 1'b0);

    // Back-to-back frames with in_valid held high across capture/emit.
    set_prod(16'h0F01, 16'h0F02, 16'h0F03, 16'h0F04);
    frame(16'h0100, 1'b0, 1'b1);
    in_data = 16'h0200;
    drain(8'hFF, 1'b0);
    chk("b2b_f1_mat", mat_flat, build_mat(16'h0100));
    set_prod(16'h0E01, 16'h0E02, 16'h0E03, 16'h0E04);
    send(16'h0200, 1'b0);
    chk("b2b_first_beat_busy", {255'b0, busy}, 256'd1);
    for (int k = 1; k < 20; k++) send(16'h0200 + 16'(k), 1'b0);
    in_valid = 1'b0;
    chk("b2b_f2_mat", mat_flat, build_mat(16'h0200));
    chk("b2b_f2_vec", {192'b0, vec_flat}, build_vec(16'h0210));
    drain(8'hFF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
